// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the write-back request payload.
package cpu_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_req_t;
endpackage

// File: rtl/gpr_wb_ctrl_if.sv
// Bundle of pipeline, MDU, issue and register-file signals around the write-back controller.
interface gpr_wb_ctrl_if;
   import cpu_pkg::*;

   logic                  W_Valid;
   logic [REG_ADDR_W-1:0] W_Addr;
   logic [DATA_W-1:0]     W_Data;
   logic                  Md_Valid;
   logic [REG_ADDR_W-1:0] Md_Addr;
   logic [DATA_W-1:0]     Md_Data;
   logic                  Md_Ready;
   logic                  Iss_Valid;
   logic [REG_ADDR_W-1:0] Iss_Addr;
   logic                  We;
   logic [REG_ADDR_W-1:0] A3;
   logic [DATA_W-1:0]     WD;
   logic [NUM_REGS-1:0]   Busy;
   logic                  Stall;

   modport master (
      output W_Valid, W_Addr, W_Data, Md_Valid, Md_Addr, Md_Data, Iss_Valid, Iss_Addr,
      input  Md_Ready, We, A3, WD, Busy, Stall
   );

   modport slave (
      input  W_Valid, W_Addr, W_Data, Md_Valid, Md_Addr, Md_Data, Iss_Valid, Iss_Addr,
      output Md_Ready, We, A3, WD, Busy, Stall
   );
endinterface

// File: rtl/wb_fifo.sv
// In-order FIFO buffering MDU results; head is visible combinationally, pointers wrap mod DEPTH.
module wb_fifo
   import cpu_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = wb_req_t
) (
   input  logic Clk,
   input  logic Rst,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output T     head,
   output logic full,
   output logic empty
);
   localparam int PTR_W = $clog2(DEPTH);

   T                 mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr_reg];

   // Storage carries no reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge Clk) begin
      if (do_push)
         mem[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end
endmodule

// File: rtl/gpr_wb_ctrl.sv
// Register-file write-back arbiter: pipeline writes beat queued MDU results, plus busy scoreboard
// and starvation stall. Define GPR_WB_TRACE_EN to print each register write.
module gpr_wb_ctrl
   import cpu_pkg::*;
#(
   parameter int MD_DEPTH   = 2,
   parameter int STARVE_MAX = 4
) (
   input logic         Clk,
   input logic         Rst,
   gpr_wb_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   wb_req_t               w_req;
   wb_req_t               md_req;
   wb_req_t               head;
   wb_req_t               sel_req;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic                  sel_valid;
   logic                  sel_we;
   logic                  stall;
   logic [CNT_W-1:0]      starve_reg;
   logic [CNT_W-1:0]      starve_next;
   logic [NUM_REGS-1:0]   busy_reg;
   logic [NUM_REGS-1:0]   busy_next;
   logic                  we_reg;
   logic [REG_ADDR_W-1:0] a3_reg;
   logic [DATA_W-1:0]     wd_reg;

   assign w_req  = '{addr: bus.W_Addr, data: bus.W_Data};
   assign md_req = '{addr: bus.Md_Addr, data: bus.Md_Data};

   // Ready is held low throughout reset so no push can land in a FIFO being cleared.
   assign bus.Md_Ready = Rst && !fifo_full;
   assign push         = bus.Md_Valid && bus.Md_Ready;
   assign pop          = !bus.W_Valid && !fifo_empty;
   assign sel_valid    = bus.W_Valid || !fifo_empty;
   assign sel_req      = bus.W_Valid ? w_req : head;
   assign sel_we       = sel_valid && (sel_req.addr != '0);

   wb_fifo #(
      .DEPTH (MD_DEPTH),
      .T     (wb_req_t)
   ) u_fifo (
      .Clk       (Clk),
      .Rst       (Rst),
      .push      (push),
      .push_data (md_req),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Per-register scoreboard: a new issue outranks a retiring write to the same register.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
         assign busy_next[gi] = 1'b0;
      end else begin : g_reg
         assign busy_next[gi] =
            (bus.Iss_Valid && (bus.Iss_Addr == REG_ADDR_W'(gi))) ||
            (busy_reg[gi] && !(sel_valid && (sel_req.addr == REG_ADDR_W'(gi))));
      end
   end

   assign stall = (starve_reg >= CNT_W'(STARVE_MAX));

   always_comb begin
      starve_next = '0;
      if (bus.W_Valid && !fifo_empty)
         starve_next = stall ? starve_reg : starve_reg + CNT_W'(1);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         we_reg     <= 1'b0;
         a3_reg     <= '0;
         wd_reg     <= '0;
         busy_reg   <= '0;
         starve_reg <= '0;
      end else begin
         we_reg     <= sel_we;
         busy_reg   <= busy_next;
         starve_reg <= starve_next;
         if (sel_valid) begin
            a3_reg <= sel_req.addr;
            wd_reg <= sel_req.data;
         end
      end
   end

   assign bus.We    = we_reg;
   assign bus.A3    = a3_reg;
   assign bus.WD    = wd_reg;
   assign bus.Busy  = busy_reg;
   assign bus.Stall = stall;

`ifdef GPR_WB_TRACE_EN
   always @(posedge Clk) begin
      if (Rst && sel_we)
         $display("$%0d = %h", sel_req.addr, sel_req.data);
   end
`endif
endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed bench for gpr_wb_ctrl: write arbitration, MDU FIFO ordering, starvation stall,
// scoreboard set/clear priority, $0 handling and mid-operation reset.
module tb_gpr_wb_ctrl;
   logic Clk;
   logic Rst;
   int   n_cmp;
   int   n_err;

   gpr_wb_ctrl_if bus();

   gpr_wb_ctrl #(
      .MD_DEPTH   (2),
      .STARVE_MAX (4)
   ) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.W_Valid   = 1'b0;
      bus.W_Addr    = '0;
      bus.W_Data    = '0;
      bus.Md_Valid  = 1'b0;
      bus.Md_Addr   = '0;
      bus.Md_Data   = '0;
      bus.Iss_Valid = 1'b0;
      bus.Iss_Addr  = '0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      Rst   = 1'b0;
      idle_inputs();

      // Reset state
      #12;
      chk("rst_we", 32'(bus.We), 32'd0);
      chk("rst_busy", bus.Busy, 32'd0);
      chk("rst_md_ready", 32'(bus.Md_Ready), 32'd0);
      chk("rst_stall", 32'(bus.Stall), 32'd0);
      @(negedge Clk);
      Rst = 1'b1;
      #1;
      chk("post_rst_md_ready", 32'(bus.Md_Ready), 32'd1);

      // Pipeline write to reg 5 clears its busy bit
      bus.Iss_Valid = 1'b1; bus.Iss_Addr = 5'd5;
      tick();
      chk("iss5_busy", 32'(bus.Busy[5]), 32'd1);
      bus.Iss_Valid = 1'b0;
      bus.W_Valid = 1'b1; bus.W_Addr = 5'd5; bus.W_Data = 32'h1234;
      tick();
      chk("w5_we", 32'(bus.We), 32'd1);
      chk("w5_a3", 32'(bus.A3), 32'd5);
      chk("w5_wd", bus.WD, 32'h1234);
      chk("w5_busy", 32'(bus.Busy[5]), 32'd0);
      bus.W_Valid = 1'b0;
      tick();
      chk("idle_we", 32'(bus.We), 32'd0);
      chk("idle_a3_hold", 32'(bus.A3), 32'd5);
      chk("idle_wd_hold", bus.WD, 32'h1234);

      // MDU results 8, 9, 10; pipeline traffic to reg 20 lets the FIFO fill
      bus.W_Valid = 1'b1; bus.W_Addr = 5'd20; bus.W_Data = 32'h20;
      bus.Md_Valid = 1'b1; bus.Md_Addr = 5'd8; bus.Md_Data = 32'h8008;
      tick();
      chk("md_ready_1", 32'(bus.Md_Ready), 32'd1);
      chk("w20_a3", 32'(bus.A3), 32'd20);
      bus.Md_Addr = 5'd9; bus.Md_Data = 32'h9009;
      tick();
      chk("md_ready_full", 32'(bus.Md_Ready), 32'd0);
      bus.Md_Addr = 5'd10; bus.Md_Data = 32'hA00A;
      bus.W_Valid = 1'b0;
      tick();
      chk("md8_we", 32'(bus.We), 32'd1);
      chk("md8_a3", 32'(bus.A3), 32'd8);
      chk("md8_wd", bus.WD, 32'h8008);
      chk("md_ready_after_pop", 32'(bus.Md_Ready), 32'd1);
      tick();
      bus.Md_Valid = 1'b0;
      chk("md9_a3", 32'(bus.A3), 32'd9);
      chk("md9_wd", bus.WD, 32'h9009);
      tick();
      chk("md10_we", 32'(bus.We), 32'd1);
      chk("md10_a3", 32'(bus.A3), 32'd10);
      chk("md10_wd", bus.WD, 32'hA00A);
      tick();
      chk("md_drained_we", 32'(bus.We), 32'd0);

      // Starvation: one queued entry, pipeline holds W_Valid for 6 cycles
      bus.W_Valid = 1'b1; bus.W_Addr = 5'd21; bus.W_Data = 32'h21;
      bus.Md_Valid = 1'b1; bus.Md_Addr = 5'd12; bus.Md_Data = 32'h000C;
      tick();
      bus.Md_Valid = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk($sformatf("starve_c%0d_stall", i), 32'(bus.Stall), (i >= 4) ? 32'd1 : 32'd0);
         chk($sformatf("starve_c%0d_a3", i), 32'(bus.A3), 32'd21);
      end
      bus.W_Valid = 1'b0;
      tick();
      chk("starve_pop_we", 32'(bus.We), 32'd1);
      chk("starve_pop_a3", 32'(bus.A3), 32'd12);
      chk("starve_pop_wd", bus.WD, 32'h000C);
      chk("starve_pop_stall", 32'(bus.Stall), 32'd0);

      // Issue and retire of reg 3 in the same cycle: set wins
      bus.W_Valid = 1'b1; bus.W_Addr = 5'd3; bus.W_Data = 32'h33;
      bus.Iss_Valid = 1'b1; bus.Iss_Addr = 5'd3;
      tick();
      chk("r3_set_wins", 32'(bus.Busy[3]), 32'd1);
      chk("r3_we", 32'(bus.We), 32'd1);
      bus.Iss_Valid = 1'b0;
      tick();
      chk("r3_cleared", 32'(bus.Busy[3]), 32'd0);

      // Writes and issues to $0
      bus.W_Addr = 5'd0; bus.W_Data = 32'hFFFF;
      bus.Iss_Valid = 1'b1; bus.Iss_Addr = 5'd0;
      tick();
      chk("r0_we", 32'(bus.We), 32'd0);
      chk("r0_busy", bus.Busy, 32'd0);
      idle_inputs();
      tick();

      // Reset with two queued entries
      bus.W_Valid = 1'b1; bus.W_Addr = 5'd22; bus.W_Data = 32'h22;
      bus.Iss_Valid = 1'b1; bus.Iss_Addr = 5'd7;
      bus.Md_Valid = 1'b1; bus.Md_Addr = 5'd13; bus.Md_Data = 32'h130D;
      tick();
      bus.Iss_Valid = 1'b0;
      bus.Md_Addr = 5'd14; bus.Md_Data = 32'h140E;
      tick();
      bus.Md_Valid = 1'b0;
      chk("pre_rst_full", 32'(bus.Md_Ready), 32'd0);
      chk("pre_rst_busy7", 32'(bus.Busy[7]), 32'd1);
      chk("pre_rst_we", 32'(bus.We), 32'd1);
      #2;
      Rst = 1'b0;
      idle_inputs();
      #1;
      chk("mid_rst_we", 32'(bus.We), 32'd0);
      chk("mid_rst_busy", bus.Busy, 32'd0);
      chk("mid_rst_md_ready", 32'(bus.Md_Ready), 32'd0);
      chk("mid_rst_stall", 32'(bus.Stall), 32'd0);
      tick();
      @(negedge Clk);
      Rst = 1'b1;
      #1;
      chk("rel_md_ready", 32'(bus.Md_Ready), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("post_rst_c%0d_we", i), 32'(bus.We), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
